// File: rtl/regfile_dumper.sv
// regfile_dumper: debug read-out engine for the 32 x 32-bit register file.
// Walks START_ADDR..END_ADDR through a dedicated read port and streams each
// register out over a valid/ready handshake, tagged with its index.
// Optional feature macro: REGDUMP_CHECKSUM_EN appends an XOR checksum beat.
module regfile_dumper #(
  parameter int START_ADDR = 1,
  parameter int END_ADDR   = 31
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic        i_start,
  input  logic        i_abort,
  output logic [4:0]  o_rd_addr,
  input  logic [31:0] i_rdata,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic [4:0]  o_idx,
  output logic        o_last,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
`ifdef REGDUMP_CHECKSUM_EN
  localparam logic [1:0] S_CSUM = 2'd3;
`endif

  localparam logic [4:0] L_START = 5'(START_ADDR);
  localparam logic [4:0] L_END   = 5'(END_ADDR);

  logic [1:0]  r_state;
  logic [4:0]  r_addr;
  logic [31:0] r_data;
  logic [4:0]  r_idx;
  logic        r_last;
  logic        r_done;
`ifdef REGDUMP_CHECKSUM_EN
  logic [31:0] r_csum;
`endif

  logic w_at_end;
  assign w_at_end = (r_addr == L_END);

  // The read address is the walking address register itself, so it is registered.
  assign o_rd_addr = r_addr;
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = r_done;

`ifdef REGDUMP_CHECKSUM_EN
  // The checksum beat overrides the captured register payload.
  always_comb begin
    o_valid = (r_state == S_SEND) || (r_state == S_CSUM);
    o_data  = (r_state == S_CSUM) ? r_csum : r_data;
    o_idx   = (r_state == S_CSUM) ? 5'd0 : r_idx;
    o_last  = (r_state == S_CSUM) ? 1'b1 : r_last;
  end
`else
  // Beat fields come straight from the capture registers.
  always_comb begin
    o_valid = (r_state == S_SEND);
    o_data  = r_data;
    o_idx   = r_idx;
    o_last  = r_last;
  end
`endif

  // Dump FSM: start/abort arbitration, register capture, handshake and done pulse.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= S_IDLE;
      r_addr  <= 5'd0;
      r_data  <= 32'd0;
      r_idx   <= 5'd0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      r_csum  <= 32'd0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Abort wins over a simultaneous start.
          if (i_start && !i_abort) begin
            r_addr  <= L_START;
            r_state <= S_LOAD;
`ifdef REGDUMP_CHECKSUM_EN
            r_csum  <= 32'd0;
`endif
          end
        end
        S_LOAD: begin
          if (i_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_data  <= i_rdata;
            r_idx   <= r_addr;
`ifdef REGDUMP_CHECKSUM_EN
            r_last  <= 1'b0;
`else
            r_last  <= w_at_end;
`endif
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (i_abort) begin
            r_state <= S_IDLE;
          end else if (i_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
            r_csum <= r_csum ^ r_data;
`endif
            if (!w_at_end) begin
              r_addr  <= r_addr + 5'd1;
              r_state <= S_LOAD;
            end else begin
`ifdef REGDUMP_CHECKSUM_EN
              r_state <= S_CSUM;
`else
              r_state <= S_IDLE;
              r_done  <= 1'b1;
`endif
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        S_CSUM: begin
          if (i_abort) begin
            r_state <= S_IDLE;
          end else if (i_ready) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper with default parameters.
// Honours REGDUMP_CHECKSUM_EN when compiled with it.
module tb_regfile_dumper;

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start;
  logic        abort;
  logic        ready;
  logic [4:0]  rd_addr;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] data;
  logic [4:0]  idx;
  logic        last;
  logic        busy;
  logic        done;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  // Register-file model: reg[0] reads 0, reg[i] = 0x1000_0000 + i.
  assign rdata = (rd_addr == 5'd0) ? 32'd0 : (32'h1000_0000 + 32'(rd_addr));

  regfile_dumper dut (
    .i_clk     (clk),
    .i_arst_n  (arst_n),
    .i_start   (start),
    .i_abort   (abort),
    .o_rd_addr (rd_addr),
    .i_rdata   (rdata),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_data    (data),
    .o_idx     (idx),
    .o_last    (last),
    .o_busy    (busy),
    .o_done    (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdaddr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_valid"},  32'(valid),   32'd0);
    chk({tag, "_data"},   data,         32'd0);
    chk({tag, "_idx"},    32'(idx),     32'd0);
    chk({tag, "_last"},   32'(last),    32'd0);
    chk({tag, "_busy"},   32'(busy),    32'd0);
    chk({tag, "_done"},   32'(done),    32'd0);
  endtask

  // One dump from IDLE; optional stall on one index, abort on one index,
  // or a stray start pulse mid-dump.
  task automatic run_dump(input int stall_idx, input int stall_n, input int abort_idx, input bit poke);
    int e, cyc, beats, stalls, done_cyc;
    logic [31:0] csum, exp_d;
    logic exp_l;
    e = 1; cyc = 0; beats = 0; stalls = 0; done_cyc = -1; csum = 32'd0;
    start = 1'b1; ready = 1'b1;
    step();
    start = 1'b0;
    chk("load_busy",   32'(busy),    32'd1);
    chk("load_valid",  32'(valid),   32'd0);
    chk("load_rdaddr", 32'(rd_addr), 32'd1);
    while (cyc < 300) begin
      step();
      cyc++;
      start = 1'b0;
      if (cyc == 1) chk("first_valid", 32'(valid), 32'd1);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (valid) begin
        exp_d = (e == 32) ? csum : (32'h1000_0000 + 32'(e));
        exp_l = CS ? (e == 32) : (e == 31);
        chk("beat_idx",  32'(idx),  (e == 32) ? 32'd0 : 32'(e));
        chk("beat_data", data,      exp_d);
        chk("beat_last", 32'(last), 32'(exp_l));
        if (abort_idx != 0 && e == abort_idx) begin
          abort = 1'b1;
          step();
          abort = 1'b0;
          chk("abort_valid", 32'(valid), 32'd0);
          chk("abort_busy",  32'(busy),  32'd0);
          chk("abort_done",  32'(done),  32'd0);
          step();
          chk("abort_done2", 32'(done),  32'd0);
          chk("abort_busy2", 32'(busy),  32'd0);
          return;
        end
        if (e == stall_idx && stalls < stall_n) begin
          ready = 1'b0;
          stalls++;
        end else begin
          ready = 1'b1;
          csum  = csum ^ exp_d;
          e++;
          beats++;
        end
      end else begin
        ready = 1'b1;
      end
      if (poke && cyc == 6) start = 1'b1;
    end
    ready = 1'b1;
    chk("done_cycle", 32'(done_cyc), 32'((CS ? 63 : 62) + stall_n));
    chk("beat_count", 32'(beats),    CS ? 32'd32 : 32'd31);
    chk("done_busy",  32'(busy),     32'd0);
    step();
    chk("done_pulse", 32'(done),     32'd0);
  endtask

  initial begin
    arst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
    #12;
    chk_all_zero("reset");
    arst_n = 1'b1;
    step();

    // Basic dump, then backpressure on idx 3, then stray start mid-dump.
    run_dump(0, 0, 0, 1'b0);
    run_dump(3, 5, 0, 1'b0);
    run_dump(0, 0, 0, 1'b1);

    // Start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("startabort_busy",  32'(busy),  32'd0);
    chk("startabort_valid", 32'(valid), 32'd0);
    step();
    chk("startabort_busy2", 32'(busy),  32'd0);

    // Abort while idx 10 is presented, then a fresh dump from idx 1.
    run_dump(0, 0, 10, 1'b0);
    run_dump(0, 0, 0, 1'b0);

    // Asynchronous reset between edges while in LOAD.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("prereset_busy",   32'(busy),    32'd1);
    chk("prereset_rdaddr", 32'(rd_addr), 32'd1);
    #2 arst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    #2 arst_n = 1'b1;
    step();
    chk("postreset_busy",  32'(busy),  32'd0);
    chk("postreset_valid", 32'(valid), 32'd0);
    step();
    chk("postreset_busy2", 32'(busy),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
